// File: rtl/md_if.sv
// Multiply/divide request bus between the pipeline (master) and the HI/LO sequencer (slave).
interface md_if;
    logic        start;
    logic        mult;
    logic        signed_calc;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hilo_wdata;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, mult, signed_calc, md_a, md_b, flush, hi_we, lo_we, hilo_wdata,
        input  stall, done, hi, lo
    );

    modport slave (
        input  start, mult, signed_calc, md_a, md_b, flush, hi_we, lo_we, hilo_wdata,
        output stall, done, hi, lo
    );
endinterface

// File: rtl/md_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO: fixed-latency multiply,
// 32-step restoring divide on magnitudes with sign fix-up at the end.
module md_ctrl #(
    parameter int MULT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    md_if.slave  bus
);
    localparam int DIV_STEPS = 32;
    localparam int CNT_W     = (MULT_CYCLES > DIV_STEPS) ? $clog2(MULT_CYCLES) : $clog2(DIV_STEPS);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [31:0] rem_reg;
    logic [31:0] quot_reg;
    logic [31:0] abs_a_reg;
    logic [31:0] abs_b_reg;
    logic        sa_reg;
    logic        sb_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic        done_reg;

    logic        idle_like;
    logic        accept;
    logic        sa_in;
    logic        sb_in;
    logic [31:0] abs_a_in;
    logic [31:0] abs_b_in;
    logic [63:0] prod_mag;
    logic [63:0] prod;
    logic [32:0] rem_sh;
    logic [32:0] rem_diff;
    logic        div_ge;
    logic [31:0] rem_step;
    logic [31:0] quot_step;
    logic        unused_rem_top;

    assign idle_like = (state_reg == IDLE) || (state_reg == DONE);
    assign accept    = bus.start && !bus.flush && idle_like;

    assign sa_in    = bus.signed_calc & bus.md_a[31];
    assign sb_in    = bus.signed_calc & bus.md_b[31];
    assign abs_a_in = sa_in ? (~bus.md_a + 32'd1) : bus.md_a;
    assign abs_b_in = sb_in ? (~bus.md_b + 32'd1) : bus.md_b;

    assign prod_mag = {32'd0, abs_a_reg} * {32'd0, abs_b_reg};
    assign prod     = (sa_reg ^ sb_reg) ? (~prod_mag + 64'd1) : prod_mag;

    // Stored remainder is always below the divisor, so 32 bits hold it; only the
    // shifted value needs the 33rd bit for the compare/subtract.
    assign rem_sh         = {rem_reg, quot_reg[31]};
    assign rem_diff       = rem_sh - {1'b0, abs_b_reg};
    assign div_ge         = (rem_sh >= {1'b0, abs_b_reg});
    assign rem_step       = div_ge ? rem_diff[31:0] : rem_sh[31:0];
    assign quot_step      = {quot_reg[30:0], div_ge};
    assign unused_rem_top = rem_diff[32];

    assign bus.stall = (state_reg == MUL) || (state_reg == DIV) || accept;
    assign bus.done  = done_reg;
    assign bus.hi    = hi_reg;
    assign bus.lo    = lo_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            rem_reg   <= '0;
            quot_reg  <= '0;
            abs_a_reg <= '0;
            abs_b_reg <= '0;
            sa_reg    <= 1'b0;
            sb_reg    <= 1'b0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    // MTHI/MTLO first so a same-edge divide-by-zero result takes precedence.
                    if (bus.hi_we) hi_reg <= bus.hilo_wdata;
                    if (bus.lo_we) lo_reg <= bus.hilo_wdata;
                    state_reg <= IDLE;
                    if (accept) begin
                        sa_reg    <= sa_in;
                        sb_reg    <= sb_in;
                        abs_a_reg <= abs_a_in;
                        abs_b_reg <= abs_b_in;
                        if (bus.mult) begin
                            state_reg <= MUL;
                            cnt_reg   <= CNT_W'(MULT_CYCLES - 1);
                        end else if (bus.md_b != 32'd0) begin
                            state_reg <= DIV;
                            cnt_reg   <= CNT_W'(DIV_STEPS - 1);
                            rem_reg   <= '0;
                            quot_reg  <= abs_a_in;
                        end else begin
                            state_reg <= DONE;
                            hi_reg    <= bus.md_a;
                            lo_reg    <= 32'hFFFF_FFFF;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    if (bus.flush) begin
                        state_reg <= IDLE;
                    end else if (cnt_reg == '0) begin
                        hi_reg    <= prod[63:32];
                        lo_reg    <= prod[31:0];
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                DIV: begin
                    if (bus.flush) begin
                        state_reg <= IDLE;
                    end else begin
                        rem_reg  <= rem_step;
                        quot_reg <= quot_step;
                        if (cnt_reg == '0) begin
                            lo_reg    <= (sa_reg ^ sb_reg) ? (~quot_step + 32'd1) : quot_step;
                            hi_reg    <= sa_reg ? (~rem_step + 32'd1) : rem_step;
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg - 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_md_ctrl.sv
// Scoreboard bench for md_ctrl: directed corner cases plus randomized MULT/DIV traffic.
module tb_md_ctrl;
    localparam int MC = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    md_if bus ();

    md_ctrl #(.MULT_CYCLES(MC)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          at;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          cur_lat = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the sign-interpreted operands.
    function automatic void ref_model(input logic m, input logic s, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] h,
                                      output logic [31:0] l);
        longint va, vb, p, q, r;
        va = s ? longint'($signed(a)) : longint'({32'd0, a});
        vb = s ? longint'($signed(b)) : longint'({32'd0, b});
        if (m) begin
            p = va * vb;
            h = p[63:32];
            l = p[31:0];
        end else if (b == 32'd0) begin
            h = a;
            l = 32'hFFFF_FFFF;
        end else begin
            q = va / vb;
            r = va % vb;
            h = r[31:0];
            l = q[31:0];
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0 cyc=%0d", cyc);
            end else begin
                mon_e = sb.pop_front();
                check32({mon_e.name, "_hi"}, bus.hi, mon_e.hi);
                check32({mon_e.name, "_lo"}, bus.lo, mon_e.lo);
                check32({mon_e.name, "_done_cycle"}, cyc, mon_e.at);
                $display("txn %s hi=%h lo=%h cyc=%0d", mon_e.name, bus.hi, bus.lo, cyc);
            end
        end
    end

    // Called at a negedge: presents the request for one cycle and queues its result.
    task automatic issue(input logic m, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input string name);
        exp_t        e;
        logic [31:0] h, l;
        ref_model(m, s, a, b, h, l);
        cur_lat = m ? MC + 1 : ((b == 32'd0) ? 1 : 33);
        bus.start = 1'b1;
        bus.mult = m;
        bus.signed_calc = s;
        bus.md_a = a;
        bus.md_b = b;
        e.hi = h;
        e.lo = l;
        e.at = cyc + cur_lat;
        e.name = name;
        sb.push_back(e);
        m_hi = h;
        m_lo = l;
        #1;
        check32({name, "_stall_req"}, {31'd0, bus.stall}, 32'd1);
    endtask

    task automatic wait_op(input string name, input bit chk_stall);
        int n = 1;
        bit seen = 0;
        for (int k = 0; k < 60; k++) begin
            if (bus.done) begin
                seen = 1;
                break;
            end
            if (bus.stall) n++;
            @(negedge clk);
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_done required=done", name);
        end
        if (chk_stall) check32({name, "_stall_cycles"}, n, cur_lat);
    endtask

    task automatic run_op(input logic m, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input string name);
        issue(m, s, a, b, name);
        @(negedge clk);
        bus.start = 1'b0;
        bus.md_a = $urandom;
        bus.md_b = $urandom;
        wait_op(name, 1'b1);
    endtask

    task automatic mt_write(input bit to_hi, input logic [31:0] d, input string name);
        bus.hi_we = to_hi;
        bus.lo_we = !to_hi;
        bus.hilo_wdata = d;
        @(negedge clk);
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        if (to_hi) m_hi = d;
        else m_lo = d;
        check32({name, "_hi"}, bus.hi, m_hi);
        check32({name, "_lo"}, bus.lo, m_lo);
    endtask

    initial begin
        logic [31:0] sv_hi, sv_lo, ra, rb;
        logic        rm, rs;
        bit          b2b;
        bus.start = 1'b0;
        bus.mult = 1'b0;
        bus.signed_calc = 1'b0;
        bus.md_a = '0;
        bus.md_b = '0;
        bus.flush = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.hilo_wdata = '0;
        repeat (2) @(negedge clk);
        check32("reset_hi", bus.hi, 32'd0);
        check32("reset_lo", bus.lo, 32'd0);
        check32("reset_done", {31'd0, bus.done}, 32'd0);
        check32("reset_stall", {31'd0, bus.stall}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h2, "mult_neg1x2");
        @(negedge clk);
        run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h2, "multu_ffx2");
        @(negedge clk);
        run_op(1'b0, 1'b0, 32'd100, 32'd7, "divu_100_7");
        @(negedge clk);
        run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'h2, "div_m7_2");
        @(negedge clk);
        run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        @(negedge clk);
        run_op(1'b0, 1'b1, 32'h1234, 32'h0, "div_by_zero");

        // MTHI in the DONE cycle overrides the result just written.
        mt_write(1'b1, 32'hCAFE_0001, "mthi_in_done");
        mt_write(1'b0, 32'h0BAD_F00D, "mtlo_idle");

        // Flush mid-divide: no done, HI/LO untouched.
        sv_hi = m_hi;
        sv_lo = m_lo;
        issue(1'b0, 1'b0, 32'd12345, 32'd67, "div_flushed");
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        void'(sb.pop_back());
        m_hi = sv_hi;
        m_lo = sv_lo;
        check32("flush_stall", {31'd0, bus.stall}, 32'd0);
        check32("flush_hi", bus.hi, m_hi);
        check32("flush_lo", bus.lo, m_lo);
        repeat (40) @(negedge clk);

        // flush wins over start in IDLE (a divide-by-zero would otherwise finish next cycle).
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.mult = 1'b0;
        bus.md_a = 32'h5555_5555;
        bus.md_b = 32'd0;
        #1;
        check32("flush_start_stall", {31'd0, bus.stall}, 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check32("flush_start_done", {31'd0, bus.done}, 32'd0);
        check32("flush_start_hi", bus.hi, m_hi);

        // Back-to-back: second request accepted in the DONE cycle.
        @(negedge clk);
        run_op(1'b1, 1'b0, 32'h0001_0003, 32'h0002_0005, "b2b_first");
        issue(1'b1, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, "b2b_second");
        @(negedge clk);
        bus.start = 1'b0;
        wait_op("b2b_second", 1'b1);

        // MTHI while dividing is ignored; the result lands normally.
        @(negedge clk);
        sv_hi = m_hi;
        issue(1'b0, 1'b0, 32'd1000, 32'd33, "div_mthi");
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.hi_we = 1'b1;
        bus.hilo_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.hi_we = 1'b0;
        check32("mthi_during_div", bus.hi, sv_hi);
        wait_op("div_mthi", 1'b0);

        // Reset mid-multiply.
        @(negedge clk);
        mt_write(1'b1, 32'h1111_2222, "pre_reset_mthi");
        issue(1'b1, 1'b1, 32'd77, 32'd88, "mul_reset");
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check32("rst_mid_hi", bus.hi, 32'd0);
        check32("rst_mid_lo", bus.lo, 32'd0);
        check32("rst_mid_stall", {31'd0, bus.stall}, 32'd0);
        void'(sb.pop_back());
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;

        b2b = 0;
        for (int i = 0; i < 30; i++) begin
            if (!b2b) @(negedge clk);
            rm = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 9))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = $urandom_range(1, 20);
                default: rb = $urandom;
            endcase
            run_op(rm, rs, ra, rb, $sformatf("rnd%0d", i));
            b2b = ($urandom_range(0, 2) == 0);
        end

        @(negedge clk);
        check32("final_hi", bus.hi, m_hi);
        check32("final_lo", bus.lo, m_lo);
        check32("scoreboard_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
- Multi-cycle multiply/divide sequencer behind the ALU's multiply/divide request outputs (operands A/B, multiply-vs-divide select, signed select, request strobe).
- Accepts one MULT/MULTU/DIV/DIVU request and runs an iterative multiply countdown or a 32-step restoring divider.
- Owns the architectural HI/LO registers, including MTHI/MTLO writes.
- Stalls the pipeline while busy and supports flush on exceptions.

Parameters:
- MULT_CYCLES, 4, cycles spent in MUL state (≥1); the product is computed combinationally and registered on the last cycle.
- DIV_STEPS, 32, restoring-division iterations (fixed at the data width; not for override).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request strobe (ALU md AND instruction valid).
- mult  in  1  1 = multiply, 0 = divide.
- signed_calc  in  1  1 = signed operands.
- md_a  in  32  multiplicand / dividend.
- md_b  in  32  multiplier / divisor.
- flush  in  1  cancel the in-flight operation.
- hi_we  in  1  MTHI write.
- lo_we  in  1  MTLO write.
- hilo_wdata  in  32  MTHI/MTLO data.
- stall  out  1  pipeline stall request.
- done  out  1  one-cycle completion pulse.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; hi=lo=0; done=0; counter, remainder and quotient registers = 0; stall=0.
- States: IDLE, MUL, DIV, DONE.
- IDLE, start=1, flush=0: latch signs sa=signed_calc&md_a[31] and sb=signed_calc&md_b[31], plus magnitudes |a| and |b| (two's-complement negate when the sign bit is set). Then:
  - mult=1 → MUL, cnt=MULT_CYCLES-1.
  - mult=0, md_b≠0 → DIV, cnt=31, rem=0, quot=|a|.
  - mult=0, md_b==0 → DONE with hi=md_a, lo=32'hFFFFFFFF, regardless of signed_calc.
- MUL: decrement cnt each cycle. When cnt==0: product = |a|*|b| (64-bit), negated if sa^sb; {hi,lo}=product; go to DONE.
- DIV step, one per cycle, 33-bit rem:
  - {rem,quot} shifted left by 1.
  - If rem≥|b|: rem-=|b| and quot[0]=1.
  - When cnt==0: lo=quot, negated if sa^sb; hi=rem[31:0], negated if sa; go to DONE. Otherwise decrement cnt.
- Signed 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0 (wrap, no trap).
- DONE (exactly one cycle): done=1. hi/lo already hold the result.
  - start=1 → accepted exactly as in IDLE (back-to-back).
  - Otherwise → IDLE.
- stall = (state==MUL) | (state==DIV) | (start & ~flush & (state==IDLE | state==DONE)). stall is combinational, so it is high in the request cycle and low during DONE.
- Latency from the start edge:
  - Multiply: done is high in cycle MULT_CYCLES+1; stall covers MULT_CYCLES+1 cycles (request cycle included).
  - Divide: done in cycle 33.
  - Divide by zero: done in cycle 1.
- flush:
  - In MUL or DIV → IDLE next edge; hi/lo unchanged; no done.
  - In IDLE or DONE → start ignored that cycle.
  - flush has priority over start.
- hi_we/lo_we: honoured only in IDLE/DONE.
  - Takes effect the same edge as a start accepted in that cycle; the later result overwrites it.
  - In DONE the write overrides the just-written result.
  - Ignored in MUL/DIV.
- start in MUL/DIV: ignored (the pipeline is stalled and re-presents the request; it must not retrigger).
- Operands are captured at acceptance; md_a/md_b changes mid-operation have no effect.
- Reset asserted mid-operation: immediate return to IDLE, hi/lo=0.

Test Plan:
- Signed multiply: MULT 0xFFFFFFFF × 0x00000002 → done at cycle 5 (MULT_CYCLES=4); hi=0xFFFFFFFF, lo=0xFFFFFFFE; stall high cycles 0–4.
- Unsigned multiply: MULTU, same operands → hi=0x00000001, lo=0xFFFFFFFE.
- Unsigned divide: DIVU 100/7 → done at cycle 33, lo=0x0000000E, hi=0x00000002.
- Signed divides:
  - DIV -7/2 (0xFFFFFFF9/0x2) → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero: DIV 0x1234/0 → done at cycle 1, hi=0x00001234, lo=0xFFFFFFFF.
- Flush: start DIV, assert flush at cycle 10 → IDLE, no done pulse, hi/lo keep prior values.
- Back-to-back: start MULTU in the DONE cycle → no IDLE gap, second done at cycle MULT_CYCLES+1 after DONE.
- MTHI during DIV: ignored.
- rst_n low mid-MUL: hi=lo=0, stall=0 immediately.
